// File: rtl/adder_nbit_pipe_if.sv
// adder_nbit_pipe_if
//   Streaming bundle for the pipelined adder.
//   Operand side : in_valid, in_ready, a, b, carry_in
//   Result side  : out_valid, out_ready, out_sum, overflow
//   Modports     : master = operand producer / result consumer
//                  slave  = the adder itself
interface adder_nbit_pipe_if #(
   parameter int NUM_BITS = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [NUM_BITS-1:0] a;
   logic [NUM_BITS-1:0] b;
   logic                carry_in;
   logic                out_valid;
   logic                out_ready;
   logic [NUM_BITS-1:0] out_sum;
   logic                overflow;

   modport master (
      output in_valid, a, b, carry_in, out_ready,
      input  in_ready, out_valid, out_sum, overflow
   );

   modport slave (
      input  in_valid, a, b, carry_in, out_ready,
      output in_ready, out_valid, out_sum, overflow
   );
endinterface

// File: rtl/adder_nbit_pipe.sv
// adder_nbit_pipe
//   Pipelined unsigned adder: sum = a + b + carry_in, split into
//   CHUNK_BITS-wide ripple slices, one slice per register stage.
//   NUM_STAGES = NUM_BITS / CHUNK_BITS; NUM_BITS must be a multiple of
//   CHUNK_BITS. Latency NUM_STAGES cycles, one result per cycle.
// Ports
//   clk    : rising-edge clock
//   n_rst  : asynchronous active-low reset
//   bus    : adder_nbit_pipe_if.slave (valid/ready operands in, results out)
// Build option
//   ADDER_SAT_EN : when defined, out_sum clamps to all ones on carry-out;
//                  overflow still reports the carry.
module adder_nbit_pipe #(
   parameter int NUM_BITS   = 16,
   parameter int CHUNK_BITS = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   adder_nbit_pipe_if.slave bus
);
   localparam int NUM_STAGES = NUM_BITS / CHUNK_BITS;

   // The whole pipe moves as one; a stalled output freezes every stage.
   logic advance;
   assign advance    = bus.out_ready | ~bus.out_valid;
   assign bus.in_ready = advance;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic [NUM_BITS-1:0] src_a;
      logic [NUM_BITS-1:0] src_b;
      logic [NUM_BITS-1:0] src_sum;
      logic                src_c;
      logic                src_v;
      logic [CHUNK_BITS:0] chunk_add;
      logic                vld_d, vld_q;
      logic                cry_d, cry_q;
      logic [NUM_BITS-1:0] sum_d, sum_q;

      if (k == 0) begin : g_head
         assign src_a   = bus.a;
         assign src_b   = bus.b;
         assign src_c   = bus.carry_in;
         assign src_v   = bus.in_valid;
         assign src_sum = '0;
      end else begin : g_body
         assign src_a   = g_stage[k-1].g_opnd.a_q;
         assign src_b   = g_stage[k-1].g_opnd.b_q;
         assign src_c   = g_stage[k-1].cry_q;
         assign src_v   = g_stage[k-1].vld_q;
         assign src_sum = g_stage[k-1].sum_q;
      end

      assign chunk_add = {1'b0, src_a[k*CHUNK_BITS +: CHUNK_BITS]}
                       + {1'b0, src_b[k*CHUNK_BITS +: CHUNK_BITS]}
                       + {{CHUNK_BITS{1'b0}}, src_c};

      // sum_q carries the already-finished lower chunks forward, so every
      // chunk of a transaction reaches the output in the same cycle.
      always_comb begin
         vld_d = vld_q;
         cry_d = cry_q;
         sum_d = sum_q;
         if (advance) begin
            vld_d = src_v;
            cry_d = chunk_add[CHUNK_BITS];
            sum_d = src_sum;
            sum_d[k*CHUNK_BITS +: CHUNK_BITS] = chunk_add[CHUNK_BITS-1:0];
`ifdef ADDER_SAT_EN
            if (k == NUM_STAGES-1 && chunk_add[CHUNK_BITS]) begin
               sum_d = '1;
            end
`endif
         end
      end

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            vld_q <= 1'b0;
            cry_q <= 1'b0;
            sum_q <= '0;
         end else begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            sum_q <= sum_d;
         end
      end

      // The final stage has no later consumer of the operands.
      if (k < NUM_STAGES-1) begin : g_opnd
         logic [NUM_BITS-1:0] a_d, a_q;
         logic [NUM_BITS-1:0] b_d, b_q;

         always_comb begin
            a_d = a_q;
            b_d = b_q;
            if (advance) begin
               a_d = src_a;
               b_d = src_b;
            end
         end

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end

   assign bus.out_valid = g_stage[NUM_STAGES-1].vld_q;
   assign bus.out_sum   = g_stage[NUM_STAGES-1].sum_q;
   assign bus.overflow  = g_stage[NUM_STAGES-1].cry_q;
endmodule

// File: tb/tb_adder_nbit_pipe.sv
// tb_adder_nbit_pipe
//   Directed vectors with hand-computed results for adder_nbit_pipe
//   (NUM_BITS=16, CHUNK_BITS=4). Expected {overflow,sum} words are queued
//   on acceptance and popped by an independent output monitor.
module tb_adder_nbit_pipe;
   localparam int NB = 16;

`ifdef ADDER_SAT_EN
   localparam logic [NB-1:0] WRAP_FFFF_1 = 16'hFFFF;
`else
   localparam logic [NB-1:0] WRAP_FFFF_1 = 16'h0000;
`endif

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   adder_nbit_pipe_if #(.NUM_BITS(NB)) bus ();

   adder_nbit_pipe #(.NUM_BITS(NB), .CHUNK_BITS(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;
   logic [NB:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Output monitor: a transfer happens at the next rising edge whenever
   // out_valid & out_ready are seen here.
   always @(negedge clk) begin
      if (n_rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(bus.out_sum), 32'hDEAD_0000);
         end else begin
            logic [NB:0] e;
            e = exp_q.pop_front();
            check("out_sum", 32'(bus.out_sum), 32'(e[NB-1:0]));
            check("overflow", 32'(bus.overflow), 32'(e[NB]));
         end
      end
   end

   // Presents one operand set and holds it until accepted.
   task automatic send(input logic [NB-1:0] av, input logic [NB-1:0] bv,
                       input logic cv, input logic [NB:0] exp);
      bit taken = 1'b0;
      bus.a        = av;
      bus.b        = bv;
      bus.carry_in = cv;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(exp);
            taken = 1'b1;
            break;
         end
      end
      if (!taken) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.out_valid) begin
            done = 1'b1;
            break;
         end
      end
      check({"drain_", name}, 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   logic [NB-1:0] stream_exp [8] = '{16'h0101, 16'h1213, 16'h2323, 16'h3435,
                                     16'h4545, 16'h5657, 16'h6767, 16'h7879};

   initial begin
      int lat;
      int v_cnt, v_first, v_last;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.carry_in  = 1'b0;
      bus.out_ready = 1'b1;
      n_rst         = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sum", 32'(bus.out_sum), 32'h0000);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single add and latency
      send(16'h1234, 16'h4321, 1'b1, {1'b0, 16'h5556});
      lat = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid) break;
      end
      check("latency", 32'(lat), 32'd4);
      wait_drain("single");

      // Carry chain and extremes
      send(16'h000F, 16'h0001, 1'b0, {1'b0, 16'h0010});
      send(16'hFFFF, 16'h0001, 1'b0, {1'b1, WRAP_FFFF_1});
      send(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF});
      wait_drain("carry");

      // Streaming: 8 back-to-back, expect 8 consecutive valid cycles
      v_cnt = 0; v_first = -1; v_last = -1;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(16'(i * 16'h1111), 16'h0101, i[0], {1'b0, stream_exp[i]});
         end
         begin
            for (int t = 0; t < 20; t++) begin
               @(negedge clk);
               if (bus.out_valid) begin
                  v_cnt++;
                  if (v_first < 0) v_first = t;
                  v_last = t;
               end
            end
         end
      join
      check("stream_count", 32'(v_cnt), 32'd8);
      check("stream_span", 32'(v_last - v_first), 32'd7);
      wait_drain("stream");

      // Backpressure: first result waiting, three more in flight
      send(16'h0001, 16'h0002, 1'b0, {1'b0, 16'h0003});
      send(16'h1000, 16'h2000, 1'b1, {1'b0, 16'h3001});
      send(16'h7FFF, 16'h0001, 1'b1, {1'b0, 16'h8001});
      send(16'hABCD, 16'h1111, 1'b0, {1'b0, 16'hBCDE});
      bus.out_ready = 1'b0;
      bus.a         = 16'h00FF;
      bus.b         = 16'h0F01;
      bus.carry_in  = 1'b0;
      bus.in_valid  = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_out_valid", 32'(bus.out_valid), 32'd1);
         check("stall_out_sum", 32'(bus.out_sum), 32'h0003);
         check("stall_overflow", 32'(bus.overflow), 32'd0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(16'h00FF, 16'h0F01, 1'b0, {1'b0, 16'h1000});
      wait_drain("backpressure");

      // Mid-flight reset
      send(16'h0011, 16'h0022, 1'b0, {1'b0, 16'h0033});
      send(16'h0044, 16'h0055, 1'b0, {1'b0, 16'h0099});
      send(16'h0100, 16'h0200, 1'b1, {1'b0, 16'h0301});
      @(posedge clk);
      #1;
      check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
      n_rst = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_out_sum", 32'(bus.out_sum), 32'h0000);
      exp_q.delete();
      @(negedge clk);
      n_rst = 1'b1;
      v_cnt = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (bus.out_valid) v_cnt++;
      end
      check("post_reset_no_stale", 32'(v_cnt), 32'd0);
      @(posedge clk);
      #1;
      send(16'h0F0F, 16'h00F1, 1'b0, {1'b0, 16'h1000});
      wait_drain("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/adder_nbit_pipe.md
Name: adder_nbit_pipe

Overview:
- Parametrised, pipelined N-bit unsigned adder with carry-in and overflow (carry-out).
- Successor to the fixed 8-bit combinational adder.
- Splits the add into CHUNK_BITS-wide ripple slices, one slice per pipeline stage, so wide adds close timing.
- Valid/ready streaming interface with full backpressure; sits between operand-producing datapath logic and result consumers.

Parameters:
NUM_BITS, 16, operand and sum width; must be a multiple of CHUNK_BITS and at least CHUNK_BITS.
CHUNK_BITS, 4, bits added per pipeline stage; NUM_STAGES = NUM_BITS / CHUNK_BITS is derived, not a parameter.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, carry_in valid this cycle.
in_ready  output  1  adder accepts the operand set this cycle.
a  input  NUM_BITS  operand A, unsigned.
b  input  NUM_BITS  operand B, unsigned.
carry_in  input  1  carry into bit 0.
out_valid  output  1  out_sum and overflow hold a result.
out_ready  input  1  consumer accepts the result this cycle.
out_sum  output  NUM_BITS  (a + b + carry_in) mod 2^NUM_BITS.
overflow  output  1  carry out of bit NUM_BITS-1.

Behaviour:
- Reset (n_rst=0, asynchronous): all stage valid bits, chunk registers, carry registers, out_sum, overflow and out_valid clear to 0. in_ready is combinational and therefore reads 1 while in reset-released idle.
- Pipeline: NUM_STAGES register stages.
  - Stage k adds chunk k of a and b plus the carry from stage k-1; stage 0 uses carry_in.
  - Stage k registers its sum chunk, its carry-out, and the still-unused upper operand chunks.
  - Completed lower sum chunks are delayed so all chunks of one transaction leave together (deskew).
- Latency: a transaction accepted at edge T appears on out_valid/out_sum/overflow after edge T+NUM_STAGES-1, i.e. NUM_STAGES cycles from acceptance with out_ready held at 1.
- Throughput: one transaction per cycle when out_ready=1.
- Handshake:
  - advance = out_ready | ~out_valid; in_ready = advance.
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - When advance=0, every stage register, including the outputs, holds its value. out_sum and overflow must stay stable while out_valid=1 and out_ready=0.
  - When advance=1 and in_valid=0, a bubble (valid bit 0) enters stage 0. Bubbles propagate and never raise out_valid.
  - in_valid may be asserted with in_ready=0; the operands are not taken, and the producer must hold them.
- Arithmetic: unsigned. overflow is bit NUM_BITS of the full (NUM_BITS+1)-bit sum. Maximum input 2^NUM_BITS-1 + 2^NUM_BITS-1 + 1 gives all-ones sum with overflow=1.
- Ordering: results exit in acceptance order; none are dropped or duplicated.
- Reset mid-operation: all in-flight transactions are discarded, out_valid drops immediately (asynchronously), and no stale result appears after release.
- Degenerate case NUM_STAGES=1: single-register adder, latency 1, same handshake.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined: when the final carry-out is 1, out_sum is forced to all ones (saturating unsigned add). overflow still reports 1, so the consumer can detect that clamping occurred.
- Not defined: out_sum wraps modulo 2^NUM_BITS, and no saturation logic is synthesised.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset check (NUM_BITS=16, CHUNK_BITS=4): hold n_rst=0 -> out_valid=0, out_sum=0x0000, overflow=0, in_ready=1 after release.
- Single add with out_ready=1: 0x1234 + 0x4321 + 1 -> out_sum=0x5556, overflow=0, out_valid high exactly 4 cycles after acceptance.
- Carry chain with out_ready=1: 0x000F + 0x0001 + 0 -> 0x0010, overflow=0. 0xFFFF + 0x0001 + 0 -> 0x0000, overflow=1 (with ADDER_SAT_EN: 0xFFFF, overflow=1). 0xFFFF + 0xFFFF + 1 -> 0xFFFF, overflow=1.
- Streaming: 8 back-to-back transactions a=i*0x1111, b=0x0101, cin=i[0], out_ready=1 -> 8 consecutive out_valid cycles with matching sums, in order.
- Backpressure: drive out_ready=0 for 3 cycles while out_valid=1 and 3 more transactions are in flight -> in_ready=0, out_sum/overflow stable, then all results drain in order with none lost.
- Mid-flight reset: accept 3 transactions, pulse n_rst low for half a cycle -> out_valid=0 at once and stays 0 until new input, with no stale sums emitted.
